// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants and types for the seven-segment scan reader:
//               segment patterns (abcdefg, a = bit 6, 1 = lit), capture FSM
//               states and one-hot helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    // Capture FSM: wait for a one-hot enable, count a stable dwell, then hold
    // until the bus moves so a single dwell is captured only once.
    typedef enum logic [1:0] {
        CAP_IDLE   = 2'd0,
        CAP_SETTLE = 2'd1,
        CAP_HELD   = 2'd2
    } cap_state_t;

    // Exactly one bit set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Slot number of a one-hot enable; only meaningful when v is one-hot.
    function automatic logic [1:0] digit_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[1]) idx = 2'd1;
        if (v[2]) idx = 2'd2;
        if (v[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pattern_decode
// Description : Combinational seven-segment pattern to hex nibble decoder.
//               o_valid is low for any pattern outside the 16-glyph set,
//               including a blank digit.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_valid
);

    // Full lookup of the glyph table; unknown patterns decode to 0 / invalid.
    always_comb begin
        o_nibble = 4'h0;
        o_valid  = 1'b1;
        case (i_pattern)
            SEG_0:   o_nibble = 4'h0;
            SEG_1:   o_nibble = 4'h1;
            SEG_2:   o_nibble = 4'h2;
            SEG_3:   o_nibble = 4'h3;
            SEG_4:   o_nibble = 4'h4;
            SEG_5:   o_nibble = 4'h5;
            SEG_6:   o_nibble = 4'h6;
            SEG_7:   o_nibble = 4'h7;
            SEG_8:   o_nibble = 4'h8;
            SEG_9:   o_nibble = 4'h9;
            SEG_A:   o_nibble = 4'hA;
            SEG_B:   o_nibble = 4'hB;
            SEG_C:   o_nibble = 4'hC;
            SEG_D:   o_nibble = 4'hD;
            SEG_E:   o_nibble = 4'hE;
            SEG_F:   o_nibble = 4'hF;
            default: o_valid  = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_reader
// Description : Samples a multiplexed four-digit seven-segment bus, decodes
//               each settled digit, assembles frames and publishes a 16-bit
//               value once the same frame repeats STABLE_FRAMES times.
//               Build option SSEG_SCAN_READER_ACTIVE_LOW_EN: seg/an are
//               inverted after the synchronizer (active-low boards).
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_reader
    import sseg_pkg::*;
#(
    parameter int SETTLE        = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic        locked,
    output logic        err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);

    logic [6:0]  r_seg_m, r_seg_s, r_seg_p;
    logic [3:0]  r_an_m, r_an_s, r_an_p;
    logic [6:0]  w_seg;
    logic [3:0]  w_an;
    cap_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic        w_change, w_an_oh, w_capture;
    logic [1:0]  w_idx;
    logic [3:0]  w_nib;
    logic        w_dec_ok;

    logic [NUM_DIGITS-1:0][3:0] r_digits;
    logic [NUM_DIGITS-1:0]      r_mask;
    logic [15:0]   r_cand;
    logic [MW-1:0] r_match;
    logic [MW-1:0] w_match_inc;
    logic          r_publish;
    logic [15:0]   r_value;
    logic          r_valid, r_locked, r_err;

    // Two-flop synchronizer on the asynchronous display bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_m <= 7'd0;
            r_seg_s <= 7'd0;
            r_an_m  <= 4'd0;
            r_an_s  <= 4'd0;
        end else begin
            r_seg_m <= seg;
            r_seg_s <= r_seg_m;
            r_an_m  <= an;
            r_an_s  <= r_an_m;
        end
    end

`ifdef SSEG_SCAN_READER_ACTIVE_LOW_EN
    assign w_seg = ~r_seg_s;
    assign w_an  = ~r_an_s;
`else
    assign w_seg = r_seg_s;
    assign w_an  = r_an_s;
`endif

    assign w_change  = (w_an != r_an_p) || (w_seg != r_seg_p);
    assign w_an_oh   = is_onehot4(w_an);
    assign w_idx     = digit_index(w_an);
    assign w_cnt_inc = r_cnt + CW'(1);
    // Last settling cycle of an unchanged one-hot dwell.
    assign w_capture = (r_state == CAP_SETTLE) && !w_change && w_an_oh &&
                       (w_cnt_inc == CW'(SETTLE));

    sseg_pattern_decode u_decode (
        .i_pattern (w_seg),
        .o_nibble  (w_nib),
        .o_valid   (w_dec_ok)
    );

    // Capture FSM plus previous-cycle copy of the bus used for change detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CAP_IDLE;
            r_cnt   <= '0;
            r_seg_p <= 7'd0;
            r_an_p  <= 4'd0;
        end else begin
            r_seg_p <= w_seg;
            r_an_p  <= w_an;
            case (r_state)
                CAP_IDLE: begin
                    if (w_an_oh) begin
                        r_state <= CAP_SETTLE;
                        r_cnt   <= CW'(1);
                    end
                end
                CAP_SETTLE: begin
                    if (w_change || !w_an_oh) begin
                        r_state <= CAP_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_capture) r_state <= CAP_HELD;
                    end
                end
                CAP_HELD: begin
                    if (w_change) r_state <= CAP_IDLE;
                end
                default: r_state <= CAP_IDLE;
            endcase
        end
    end

    assign w_match_inc = r_match + MW'(1);

    // Frame assembly, repeat counting and publication. The capture branch is
    // last so an invalid glyph overrides anything else in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits  <= '0;
            r_mask    <= '0;
            r_cand    <= 16'h0000;
            r_match   <= '0;
            r_publish <= 1'b0;
            r_value   <= 16'h0000;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_publish <= 1'b0;

            if (r_publish) begin
                r_value  <= r_cand;
                r_valid  <= 1'b1;
                r_locked <= 1'b1;
            end

            if (r_mask == {NUM_DIGITS{1'b1}}) begin
                r_mask <= '0;
                if (r_digits == r_cand) begin
                    if (r_match != MW'(STABLE_FRAMES)) begin
                        r_match   <= w_match_inc;
                        r_publish <= (w_match_inc == MW'(STABLE_FRAMES));
                    end
                end else begin
                    r_cand    <= r_digits;
                    r_match   <= MW'(1);
                    r_locked  <= 1'b0;
                    r_publish <= (MW'(1) == MW'(STABLE_FRAMES));
                end
            end

            if (w_capture) begin
                if (w_dec_ok) begin
                    r_digits[w_idx] <= w_nib;
                    r_mask[w_idx]   <= 1'b1;
                end else begin
                    r_err     <= 1'b1;
                    r_mask    <= '0;
                    r_match   <= '0;
                    r_locked  <= 1'b0;
                    r_publish <= 1'b0;
                end
            end
        end
    end

    assign value  = r_value;
    assign valid  = r_valid;
    assign locked = r_locked;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: doc/sseg_scan_reader.md
# sseg_scan_reader

Receive-side counterpart of the seven-segment display path. It samples a time-multiplexed four-digit seven-segment bus (segment lines plus one-hot digit enables), decodes each settled segment pattern back to a hex nibble, and assembles full frames. It publishes a 16-bit value once the same frame has repeated a configurable number of times. It is used as a loopback monitor on board builds and as a checker in system benches that drive the display.

## Interface
Parameters:
- SETTLE, 4: cycles a digit enable and pattern must hold unchanged before capture (≥2).
- STABLE_FRAMES, 2: consecutive identical frames required before publishing (≥1).

Ports:
- clk  input  1  system clock; single clock domain, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- seg  input  7  segment lines {a,b,c,d,e,f,g}, a = bit 6; 1 = lit.
- an  input  4  digit enables, one-hot, an[3] = most significant digit; 1 = enabled.
- value  output  16  last published frame, digit 3 in [15:12]; reset 16'h0000.
- valid  output  1  one-cycle pulse when value is updated; reset 0.
- locked  output  1  high while incoming frames match value; reset 0.
- err  output  1  one-cycle pulse on capture of an undecodable pattern; reset 0.

## Operation
- Inputs pass through a two-flop synchronizer (seg_s, an_s); all logic below uses the synchronized copies.
- Decode map (abcdefg → nibble): 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9, 1110111→A, 0011111→b, 1001110→C, 0111101→d, 1001111→E, 1000111→F. Any other pattern, including blank, is invalid.
- Capture FSM, states IDLE, SETTLE, HELD:
  - IDLE: if an_s is one-hot → SETTLE with cnt=1. Otherwise stay in IDLE.
  - SETTLE: if an_s or seg_s differs from the previous cycle, or an_s is not one-hot → IDLE. Else cnt++; when cnt reaches SETTLE, capture into slot index(an_s) → HELD.
  - HELD: if an_s or seg_s changes → IDLE. No re-capture of the same dwell.
- On capture with a valid pattern: store the nibble and set mask[i]. Recapturing an already-set slot overwrites it.
- On capture with an invalid pattern: pulse err, clear mask, clear the match counter, drop locked. value is unchanged.
- Frame complete when mask == 4'hF, evaluated in the cycle after the capture that completes it. Mask clears in the same cycle.
  - If the frame equals the candidate: match_cnt++, saturating at STABLE_FRAMES.
  - Otherwise: the candidate becomes this frame, match_cnt = 1, and locked drops.
- When match_cnt transitions to STABLE_FRAMES (including STABLE_FRAMES=1 on the first frame): value ← candidate, valid pulses, locked ← 1. Further identical frames produce no additional pulse.
- Reset mid-frame: every register returns to its reset value (FSM IDLE, mask 0, match_cnt 0, candidate 0) and partial frames are discarded.

## Timing
- Input to internal visibility: 2 cycles of synchronizer latency.
- Digit capture: SETTLE cycles after an_s/seg_s become stable and one-hot. Minimum digit dwell at the pins is therefore SETTLE+1 cycles, including the cycle that enters IDLE.
- valid, locked, and value update together, 2 cycles after the capturing edge of the last digit of the qualifying frame.
- err is asserted in the cycle after the invalid capture.
- Simultaneous events: an invalid capture that would also complete the mask counts as invalid, so the frame is discarded.

## Configuration
- SSEG_SCAN_READER_ACTIVE_LOW_EN:
  - Defined: seg and an are inverted immediately after the synchronizer, so boards with active-low LEDs and anodes are read directly.
  - Undefined: inputs are active-high as listed in the Interface.
  - All other behaviour is identical.

## Structure
- Package sseg_pkg holds:
  - The 16 pattern constants (SEG_0 … SEG_F, 7 bits each).
  - The capture FSM state typedef.
  - NUM_DIGITS = 4.
- Sub-module sseg_pattern_decode: combinational, 7-bit pattern → 4-bit nibble plus a valid flag. It is instantiated once on seg_s and reused by the benches as a reference model.

## Test plan
- Drive each digit for 8 cycles, frame 16'h1234 repeated 2× → valid pulses once, value=16'h1234, locked=1; a third identical frame → no pulse.
- Sweep all 16 patterns on digit 0 with 16'hAB_C in the other digits → values 16'hABC0 … 16'hABCF, each published after 2 frames.
- Drive an invalid pattern 0000000 on digit 2 mid-frame → err pulses for 1 cycle, no valid, locked=0, value unchanged.
- Run 16'h1234 stable, then 16'h1235 twice → locked drops after the first 16'h1235 frame; valid and value=16'h1235 after the second.
- Use a digit dwell of SETTLE-1 cycles, or two enables high at once → no capture and no valid.
- Assert reset for 1 cycle after 3 digits of a frame → all outputs 0, and the next complete 2× frame publishes normally.
